// File: rtl/control_sequencer.sv
// control_sequencer: hardwired controller for the ArithmeticLogicUnitSystem datapath.
// Latency: one INIT cycle after reset, then 3 cycles per instruction (FETCH_L, FETCH_H, EXEC).
// Backpressure: none; datapath and memory complete every micro-step in one cycle.
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic        Illegal
);

  // Opcodes (IROut[15:10])
  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_BEQ = 6'h02;
  localparam logic [5:0] OP_LDI = 6'h03;
  localparam logic [5:0] OP_LD  = 6'h04;
  localparam logic [5:0] OP_ST  = 6'h05;
  localparam logic [5:0] OP_ADD = 6'h06;
  localparam logic [5:0] OP_SUB = 6'h07;
  localparam logic [5:0] OP_AND = 6'h08;
  localparam logic [5:0] OP_OR  = 6'h09;
  localparam logic [5:0] OP_XOR = 6'h0A;
  localparam logic [5:0] OP_HLT = 6'h3F;

  // Register file / address register file function codes
  localparam logic [2:0] RF_LOAD   = 3'b010;
  localparam logic [2:0] RF_CLEAR  = 3'b011;
  localparam logic [2:0] ARF_INC   = 3'b001;
  localparam logic [2:0] ARF_LOAD  = 3'b010;
  localparam logic [2:0] ARF_CLEAR = 3'b011;
  localparam logic [2:0] ARF_EN_PC = 3'b100;

  // ALU function codes
  localparam logic [4:0] ALU_PASS_A = 5'b10000;
  localparam logic [4:0] ALU_ADD    = 5'b10100;
  localparam logic [4:0] ALU_SUB    = 5'b10110;
  localparam logic [4:0] ALU_AND    = 5'b10111;
  localparam logic [4:0] ALU_OR     = 5'b11000;
  localparam logic [4:0] ALU_XOR    = 5'b11001;

  // Mux and address-source selects
  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b10;
  localparam logic [1:0] MUX_IMM = 2'b11;
  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b10;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH_L,
    S_FETCH_H,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state;
  state_t state_next;

  logic       halted_q;
  logic       illegal_q;

  // Instruction field decode
  logic [5:0] opcode;
  logic       zero_flag;
  logic       op_legal;
  logic       branch_taken;
  logic [3:0] dst_onehot_hi;   // one-hot of IR[9:8] for LDI/LD
  logic [3:0] dst_onehot_alu;  // one-hot of IR[7:6] for ALU ops
  logic [4:0] alu_code;

  // Only the Z flag steers branches; the other flags are carried but unused here.
  logic unused_flags;
  assign unused_flags = &{1'b0, FlagsOut[2:0]};

  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    reg_onehot = 4'b1000 >> idx;
  endfunction

  assign opcode         = IROut[15:10];
  assign zero_flag      = FlagsOut[3];
  assign dst_onehot_hi  = reg_onehot(IROut[9:8]);
  assign dst_onehot_alu = reg_onehot(IROut[7:6]);
  assign op_legal       = (opcode <= OP_XOR) || (opcode == OP_HLT);

  // Branch condition evaluated combinationally from the live flags in EXEC
  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OP_BRA:  branch_taken = 1'b1;
      OP_BNE:  branch_taken = ~zero_flag;
      OP_BEQ:  branch_taken = zero_flag;
      default: branch_taken = 1'b0;
    endcase
  end

  // ALU function code selected by the arithmetic/logic opcodes
  always_comb begin
    alu_code = ALU_PASS_A;
    case (opcode)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      OP_XOR:  alu_code = ALU_XOR;
      default: alu_code = ALU_PASS_A;
    endcase
  end

  // State register; reset always returns to INIT regardless of current state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the fetch/execute loop
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:    state_next = S_FETCH_L;
      S_FETCH_L: state_next = S_FETCH_H;
      S_FETCH_H: state_next = S_EXEC;
      S_EXEC: begin
        if (!op_legal || (opcode == OP_HLT)) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH_L;
        end
      end
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_INIT;
    endcase
  end

  // Status flags latch on the edge that enters HALT and clear only on reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if ((state == S_EXEC) && (state_next == S_HALT)) begin
      halted_q  <= 1'b1;
      illegal_q <= !op_legal;
    end
  end

  assign Halted  = halted_q;
  assign Illegal = illegal_q;

  // Control word per state; reset cycle and HALT drive only the defaults
  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = ALU_PASS_A;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 3'b000;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;

    if (!Reset) begin
      case (state)
        S_INIT: begin
          RF_FunSel  = RF_CLEAR;
          RF_RegSel  = 4'b1111;
          RF_ScrSel  = 4'b1111;
          ARF_FunSel = ARF_CLEAR;
          ARF_RegSel = 3'b111;
        end

        S_FETCH_L, S_FETCH_H: begin
          // Read M[PC] into the selected IR byte and bump PC on the same edge
          ARF_OutDSel = SEL_PC;
          Mem_CS      = 1'b0;
          IR_LH       = (state == S_FETCH_H);
          IR_Write    = 1'b1;
          ARF_FunSel  = ARF_INC;
          ARF_RegSel  = ARF_EN_PC;
        end

        S_EXEC: begin
          case (opcode)
            OP_BRA, OP_BNE, OP_BEQ: begin
              if (branch_taken) begin
                MuxBSel    = MUX_IMM;
                ARF_FunSel = ARF_LOAD;
                ARF_RegSel = ARF_EN_PC;
              end
            end

            OP_LDI: begin
              MuxASel   = MUX_IMM;
              RF_FunSel = RF_LOAD;
              RF_RegSel = dst_onehot_hi;
            end

            OP_LD: begin
              ARF_OutDSel = SEL_AR;
              Mem_CS      = 1'b0;
              MuxASel     = MUX_MEM;
              RF_FunSel   = RF_LOAD;
              RF_RegSel   = dst_onehot_hi;
            end

            OP_ST: begin
              // Register goes through the ALU unchanged onto the memory data path
              RF_OutASel  = {1'b0, IROut[9:8]};
              ALU_FunSel  = ALU_PASS_A;
              MuxCSel     = 1'b0;
              ARF_OutDSel = SEL_AR;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end

            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              // IR[9] is the set-flags bit; IR[8] carries no meaning for these ops
              RF_OutASel = IROut[5:3];
              RF_OutBSel = IROut[2:0];
              ALU_FunSel = alu_code;
              ALU_WF     = IROut[9];
              MuxASel    = MUX_ALU;
              RF_FunSel  = RF_LOAD;
              RF_RegSel  = dst_onehot_alu;
            end

            default: begin
              // HLT and unimplemented opcodes leave the datapath untouched
            end
          endcase
        end

        default: begin
          // HALT: defaults only
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed scenarios plus randomized instruction streams.
// Every cycle the whole control word is compared with a behavioural model of the instruction set.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] IROut = 16'h0000;
  logic [3:0]  FlagsOut = 4'h0;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_CS, Mem_WR;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Halted, Illegal;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] oa;   logic [2:0] ob;   logic [2:0] rff;  logic [3:0] rs;
    logic [3:0] ss;   logic [4:0] af;   logic       wf;   logic [1:0] oc;
    logic [1:0] od;   logic [2:0] arff; logic [2:0] ars;  logic       lh;
    logic       irw;  logic       cs;   logic       wr;   logic [1:0] ma;
    logic [1:0] mb;   logic       mc;   logic       hlt;  logic       ill;
  } outs_t;

  // Model phases: where the instruction cycle stands
  localparam int P_INIT = 0;
  localparam int P_FL   = 1;
  localparam int P_FH   = 2;
  localparam int P_EX   = 3;
  localparam int P_HALT = 4;

  int    m_phase   = P_INIT;
  bit    m_halted  = 1'b0;
  bit    m_illegal = 1'b0;
  int    n_checks  = 0;
  int    n_fail    = 0;
  outs_t exp_o, act_o;
  logic [4:0] alu_code [0:4] = '{5'b10100, 5'b10110, 5'b10111, 5'b11000, 5'b11001};

  // Expected control word from the instruction-set description
  function automatic outs_t model_out();
    outs_t o;
    logic [5:0] op;
    logic z, take;
    int k;
    o = '0;
    o.af = 5'b10000;
    o.cs = 1'b1;
    o.hlt = m_halted;
    o.ill = m_illegal;
    if (Reset) return o;
    op = IROut[15:10];
    z  = FlagsOut[3];
    if (m_phase == P_INIT) begin
      o.rff = 3'b011; o.rs = 4'b1111; o.ss = 4'b1111; o.arff = 3'b011; o.ars = 3'b111;
    end else if (m_phase == P_FL || m_phase == P_FH) begin
      o.od = 2'b00; o.cs = 1'b0; o.lh = (m_phase == P_FH); o.irw = 1'b1;
      o.arff = 3'b001; o.ars = 3'b100;
    end else if (m_phase == P_EX) begin
      take = (op == 6'd0) || (op == 6'd1 && !z) || (op == 6'd2 && z);
      if (take) begin
        o.mb = 2'b11; o.arff = 3'b010; o.ars = 3'b100;
      end
      if (op == 6'd3) begin
        o.ma = 2'b11; o.rff = 3'b010; o.rs = 4'b1000 >> IROut[9:8];
      end
      if (op == 6'd4) begin
        o.od = 2'b10; o.cs = 1'b0; o.ma = 2'b10; o.rff = 3'b010; o.rs = 4'b1000 >> IROut[9:8];
      end
      if (op == 6'd5) begin
        o.oa = {1'b0, IROut[9:8]}; o.od = 2'b10; o.cs = 1'b0; o.wr = 1'b1;
      end
      if (op >= 6'd6 && op <= 6'd10) begin
        k = int'(op) - 6;
        o.oa = IROut[5:3]; o.ob = IROut[2:0]; o.af = alu_code[k]; o.wf = IROut[9];
        o.ma = 2'b00; o.rff = 3'b010; o.rs = 4'b1000 >> IROut[7:6];
      end
    end
    return o;
  endfunction

  // Advance the model across the coming rising edge
  function automatic void model_step();
    logic [5:0] op;
    op = IROut[15:10];
    if (Reset) begin
      m_phase = P_INIT; m_halted = 1'b0; m_illegal = 1'b0;
    end else if (m_phase == P_INIT) m_phase = P_FL;
    else if (m_phase == P_FL) m_phase = P_FH;
    else if (m_phase == P_FH) m_phase = P_EX;
    else if (m_phase == P_EX) begin
      if (op == 6'h3F) begin
        m_phase = P_HALT; m_halted = 1'b1;
      end else if (op > 6'h0A) begin
        m_phase = P_HALT; m_halted = 1'b1; m_illegal = 1'b1;
      end else m_phase = P_FL;
    end
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o.oa = RF_OutASel;  o.ob = RF_OutBSel;  o.rff = RF_FunSel;   o.rs = RF_RegSel;
    o.ss = RF_ScrSel;   o.af = ALU_FunSel;  o.wf = ALU_WF;       o.oc = ARF_OutCSel;
    o.od = ARF_OutDSel; o.arff = ARF_FunSel; o.ars = ARF_RegSel; o.lh = IR_LH;
    o.irw = IR_Write;   o.cs = Mem_CS;      o.wr = Mem_WR;       o.ma = MuxASel;
    o.mb = MuxBSel;     o.mc = MuxCSel;     o.hlt = Halted;      o.ill = Illegal;
    return o;
  endfunction

  task automatic drive(input logic r, input logic [15:0] ir, input logic [3:0] fl);
    @(negedge Clock);
    Reset = r; IROut = ir; FlagsOut = fl;
    #1;
  endtask

  // One reset cycle followed by the INIT cycle, stimulus only
  task automatic restart();
    drive(1'b1, 16'($urandom), 4'($urandom)); model_step();
    drive(1'b0, 16'($urandom), 4'($urandom)); model_step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h0F5A, 4'hF);
      exp_o = model_out(); act_o = observe(); n_checks++;
      if (act_o !== exp_o) begin n_fail++; $display("FAIL reset_cycle%0d: got %h want %h", i, act_o, exp_o); end
      n_checks++;
      if ({IR_Write, Mem_CS, RF_RegSel, ARF_RegSel, Halted} !== {1'b0, 1'b1, 4'b0000, 3'b000, 1'b0}) begin
        n_fail++; $display("FAIL reset_defaults: got %b want %b",
          {IR_Write, Mem_CS, RF_RegSel, ARF_RegSel, Halted}, {1'b0, 1'b1, 4'b0000, 3'b000, 1'b0});
      end
      model_step();
    end
    drive(1'b0, 16'h0000, 4'h0);
    exp_o = model_out(); act_o = observe(); n_checks++;
    if (act_o !== exp_o) begin n_fail++; $display("FAIL init_word: got %h want %h", act_o, exp_o); end
    n_checks++;
    if ({RF_FunSel, RF_RegSel, RF_ScrSel, ARF_FunSel, ARF_RegSel} !== {3'b011, 4'b1111, 4'b1111, 3'b011, 3'b111}) begin
      n_fail++; $display("FAIL init_clear: got %b want %b",
        {RF_FunSel, RF_RegSel, RF_ScrSel, ARF_FunSel, ARF_RegSel}, {3'b011, 4'b1111, 4'b1111, 3'b011, 3'b111});
    end
    model_step();
    drive(1'b0, 16'h0000, 4'h0);
    exp_o = model_out(); act_o = observe(); n_checks++;
    if (act_o !== exp_o) begin n_fail++; $display("FAIL fetch_l_word: got %h want %h", act_o, exp_o); end
    n_checks++;
    if ({Mem_CS, IR_Write, IR_LH, ARF_RegSel, ARF_FunSel, ARF_OutDSel} !== {1'b0, 1'b1, 1'b0, 3'b100, 3'b001, 2'b00}) begin
      n_fail++; $display("FAIL fetch_l_fields: got %b want %b",
        {Mem_CS, IR_Write, IR_LH, ARF_RegSel, ARF_FunSel, ARF_OutDSel}, {1'b0, 1'b1, 1'b0, 3'b100, 3'b001, 2'b00});
    end
    model_step();
  endtask

  task automatic test_exec_decode();
    logic [15:0] instr [0:3] = '{16'h0F5A, 16'h1A4C, 16'h0820, 16'h0820};
    logic [3:0]  flags [0:3] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000};
    restart();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (c < 2) drive(1'b0, 16'($urandom), 4'($urandom));
        else       drive(1'b0, instr[i], flags[i]);
        exp_o = model_out(); act_o = observe(); n_checks++;
        if (act_o !== exp_o) begin n_fail++; $display("FAIL decode_i%0d_c%0d: got %h want %h", i, c, act_o, exp_o); end
        if (c == 2) begin
          n_checks++;
          if (i == 0 && {MuxASel, RF_FunSel, RF_RegSel} !== {2'b11, 3'b010, 4'b0001}) begin
            n_fail++; $display("FAIL ldi_r4: got %b want %b", {MuxASel, RF_FunSel, RF_RegSel}, {2'b11, 3'b010, 4'b0001});
          end
          if (i == 1 && {RF_OutASel, RF_OutBSel, ALU_FunSel, ALU_WF, RF_RegSel} !== {3'b001, 3'b100, 5'b10100, 1'b1, 4'b0100}) begin
            n_fail++; $display("FAIL add_s1: got %b want %b", {RF_OutASel, RF_OutBSel, ALU_FunSel, ALU_WF, RF_RegSel},
              {3'b001, 3'b100, 5'b10100, 1'b1, 4'b0100});
          end
          if (i == 2 && {MuxBSel, ARF_FunSel, ARF_RegSel} !== {2'b11, 3'b010, 3'b100}) begin
            n_fail++; $display("FAIL beq_taken: got %b want %b", {MuxBSel, ARF_FunSel, ARF_RegSel}, {2'b11, 3'b010, 3'b100});
          end
          if (i == 3 && ARF_RegSel !== 3'b000) begin
            n_fail++; $display("FAIL beq_not_taken: got %b want %b", ARF_RegSel, 3'b000);
          end
        end
        model_step();
      end
    end
  endtask

  task automatic test_halt();
    restart();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, (c == 2) ? (16'hFC00 | 16'($urandom_range(0, 1023))) : 16'($urandom), 4'($urandom));
      exp_o = model_out(); act_o = observe(); n_checks++;
      if (act_o !== exp_o) begin n_fail++; $display("FAIL hlt_fetch_c%0d: got %h want %h", c, act_o, exp_o); end
      model_step();
    end
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 16'($urandom), 4'($urandom));
      exp_o = model_out(); act_o = observe(); n_checks++;
      if (act_o !== exp_o) begin n_fail++; $display("FAIL halt_word_c%0d: got %h want %h", c, act_o, exp_o); end
      n_checks++;
      if ({Halted, Illegal, RF_RegSel, RF_ScrSel, ARF_RegSel, IR_Write, Mem_CS, Mem_WR, ALU_FunSel} !==
          {1'b1, 1'b0, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 5'b10000}) begin
        n_fail++; $display("FAIL halt_hold_c%0d: got %b", c,
          {Halted, Illegal, RF_RegSel, RF_ScrSel, ARF_RegSel, IR_Write, Mem_CS, Mem_WR, ALU_FunSel});
      end
      model_step();
    end
    drive(1'b1, 16'h0000, 4'h0);
    exp_o = model_out(); act_o = observe(); n_checks++;
    if (act_o !== exp_o) begin n_fail++; $display("FAIL halt_reset_cycle: got %h want %h", act_o, exp_o); end
    model_step();
    drive(1'b0, 16'h0000, 4'h0);
    n_checks++;
    if ({Halted, Illegal, RF_RegSel, ARF_RegSel} !== {1'b0, 1'b0, 4'b1111, 3'b111}) begin
      n_fail++; $display("FAIL halt_exit_init: got %b want %b", {Halted, Illegal, RF_RegSel, ARF_RegSel}, {1'b0, 1'b0, 4'b1111, 3'b111});
    end
    model_step();
  endtask

  task automatic test_illegal();
    restart();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, (c == 2) ? (16'h8000 | 16'($urandom_range(0, 1023))) : 16'($urandom), 4'($urandom));
      exp_o = model_out(); act_o = observe(); n_checks++;
      if (act_o !== exp_o) begin n_fail++; $display("FAIL ill_fetch_c%0d: got %h want %h", c, act_o, exp_o); end
      if (c == 2) begin
        n_checks++;
        if ({RF_RegSel, RF_ScrSel, ARF_RegSel, Mem_CS, Mem_WR, IR_Write} !== {4'b0, 4'b0, 3'b0, 1'b1, 1'b0, 1'b0}) begin
          n_fail++; $display("FAIL ill_no_write: got %b", {RF_RegSel, RF_ScrSel, ARF_RegSel, Mem_CS, Mem_WR, IR_Write});
        end
      end
      model_step();
    end
    drive(1'b0, 16'h0000, 4'h0);
    n_checks++;
    if ({Halted, Illegal} !== 2'b11) begin
      n_fail++; $display("FAIL ill_status: got %b want %b", {Halted, Illegal}, 2'b11);
    end
    model_step();
    restart();
    drive(1'b0, 16'h0000, 4'h0);
    n_checks++;
    if ({Halted, Illegal, IR_Write} !== 3'b001) begin
      n_fail++; $display("FAIL ill_cleared: got %b want %b", {Halted, Illegal, IR_Write}, 3'b001);
    end
    model_step();
  endtask

  task automatic test_reset_midflight();
    restart();
    drive(1'b0, 16'h0F5A, 4'h0); model_step();
    drive(1'b1, 16'h0F5A, 4'h0);
    n_checks++;
    if (IR_Write !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_h_irw: got %b want 0", IR_Write); end
    model_step();
    drive(1'b0, 16'h0F5A, 4'h0);
    n_checks++;
    if ({RF_RegSel, ARF_RegSel, ARF_FunSel} !== {4'b1111, 3'b111, 3'b011}) begin
      n_fail++; $display("FAIL rst_fetch_h_init: got %b want %b", {RF_RegSel, ARF_RegSel, ARF_FunSel}, {4'b1111, 3'b111, 3'b011});
    end
    model_step();
    drive(1'b0, 16'h0F5A, 4'h0); model_step();
    drive(1'b0, 16'h0F5A, 4'h0); model_step();
    drive(1'b1, 16'h0F5A, 4'h0);
    exp_o = model_out(); act_o = observe(); n_checks++;
    if (act_o !== exp_o) begin n_fail++; $display("FAIL rst_exec_word: got %h want %h", act_o, exp_o); end
    n_checks++;
    if ({RF_RegSel, MuxASel} !== {4'b0000, 2'b00}) begin
      n_fail++; $display("FAIL rst_exec_nowrite: got %b want %b", {RF_RegSel, MuxASel}, {4'b0000, 2'b00});
    end
    model_step();
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic       r;
    int         sel;
    restart();
    for (int c = 0; c < 600; c++) begin
      sel = int'($urandom_range(0, 39));
      if (sel < 33)      op = 6'(sel % 11);
      else if (sel < 36) op = 6'h3F;
      else               op = 6'($urandom_range(11, 62));
      r = (m_phase == P_HALT && $urandom_range(0, 3) == 0) || ($urandom_range(0, 59) == 0);
      drive(r, {op, 10'($urandom)}, 4'($urandom));
      exp_o = model_out(); act_o = observe(); n_checks++;
      if (act_o !== exp_o) begin
        n_fail++; $display("FAIL random_c%0d: ir %h fl %b rst %b got %h want %h", c, IROut, FlagsOut, Reset, act_o, exp_o);
      end
      model_step();
    end
  endtask

  initial begin
    test_reset();
    test_exec_decode();
    test_halt();
    test_illegal();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
